// File: rtl/slave_interface_pkg.sv
// Shared SPI slave definitions: FSM state encodings and frame geometry.
package slave_interface_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  localparam logic [3:0] RX_LAST = 4'd9;   // index of the final receive bit
  localparam logic [3:0] RX_DONE = 4'd10;  // counter value once a frame is complete
  localparam logic [2:0] TX_LAST = 3'd7;

endpackage

// File: rtl/slave_interface.sv
// SPI slave: receives 10-bit frames on MOSI and, for read-data frames, returns one byte on MISO.
module slave_interface
  import slave_interface_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic [9:0] rx_data,
  output logic       rx_valid
);

  logic [2:0] state_q, state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic [9:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [9:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_q, miso_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx_done_q, tx_done_d;
  logic       rd_addr_done_q, rd_addr_done_d;
  logic       in_frame;

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ss_n high always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (ss_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:                         state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)                  state_d = WRITE;
          else if (rd_addr_done_q)    state_d = READ_DATA;
          else                        state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA:   state_d = state_q;
        default:                      state_d = IDLE;
      endcase
    end
  end

  assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);

  // Datapath next-state and outputs
  always_comb begin
    rx_cnt_d       = rx_cnt_q;
    tx_cnt_d       = tx_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    rd_addr_done_d = rd_addr_done_q;

    if (ss_n || (state_q == IDLE)) begin
      // Partial frames and transmits are dropped; rd_addr_done survives an abort
      rx_cnt_d  = '0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
      miso_d    = 1'b0;
    end else if (in_frame) begin
      if (rx_cnt_q < RX_DONE) begin
        rx_shift_d = {rx_shift_q[8:0], MOSI};
        rx_cnt_d   = rx_cnt_q + 4'd1;
        if (rx_cnt_q == RX_LAST) begin
          rx_data_d  = {rx_shift_q[8:0], MOSI};
          rx_valid_d = 1'b1;
          if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
        end
      end

      if ((state_q == READ_DATA) && (rx_cnt_q == RX_DONE)) begin
        if (tx_busy_q) begin
          if (tx_cnt_q == TX_LAST) begin
            miso_d         = 1'b0;
            tx_busy_d      = 1'b0;
            tx_done_d      = 1'b1;
            rd_addr_done_d = 1'b0;
          end else begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            tx_cnt_d   = tx_cnt_q + 3'd1;
          end
        end else if (!tx_done_q && tx_valid) begin
          // MSB goes out on the capture edge; the rest shifts from tx_shift
          miso_d     = tx_data[7];
          tx_shift_d = {tx_data[6:0], 1'b0};
          tx_cnt_d   = '0;
          tx_busy_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_cnt_q       <= '0;
      tx_cnt_q       <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      rd_addr_done_q <= 1'b0;
    end else begin
      rx_cnt_q       <= rx_cnt_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      rd_addr_done_q <= rd_addr_done_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_slave_interface.sv
// Directed bench for slave_interface: write, read-address and read-data frames, aborts and reset.
module tb_slave_interface;
  import slave_interface_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_n;
  logic       MOSI;
  logic       MISO;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [9:0] rx_data;
  logic       rx_valid;

  int checks   = 0;
  int failures = 0;

  slave_interface dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Select, send command bit, shift 10 frame bits; ss_n stays low afterwards.
  task automatic send_frame(input string tag, input logic cmd, input logic [9:0] frame);
    int pulses = 0;
    ss_n = 1'b0;
    tick();
    MOSI = cmd;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = frame[i];
      tick();
      if (rx_valid) pulses++;
    end
    check({tag, "_rx_data"}, 32'(rx_data), 32'(frame));
    check({tag, "_rx_valid_hi"}, 32'(rx_valid), 32'd1);
    MOSI = ~frame[0];
    tick();
    if (rx_valid) pulses++;
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_rx_hold"}, 32'(rx_data), 32'(frame));
    MOSI = 1'b0;
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] exp_byte;
    int pulses;

    rst_n = 1'b1; ss_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tick();
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd0);
    rst_n = 1'b0; ss_n = 1'b1; MOSI = 1'b0;
    tick();

    // Write frame with tx_valid held high: MISO must stay quiet
    send_frame("wr1", 1'b0, 10'h0FF);
    check("wr1_state", 32'(dut.state_q), 32'(WRITE));
    check("wr1_miso", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    end_frame();

    send_frame("wr2", 1'b0, 10'h1A5);
    check("wr2_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd0);
    end_frame();

    send_frame("rda", 1'b1, 10'h20F);
    check("rda_state", 32'(dut.state_q), 32'(READ_ADD));
    check("rda_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd1);
    end_frame();

    send_frame("rdd", 1'b1, 10'h300);
    check("rdd_state", 32'(dut.state_q), 32'(READ_DATA));
    check("rdd_miso_idle", 32'(MISO), 32'd0);
    tx_valid = 1'b1; tx_data = 8'h8B;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    exp_byte = 8'h8B;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("rdd_miso_bit%0d", i), 32'(MISO), 32'(exp_byte[i]));
      tick();
    end
    check("rdd_miso_after", 32'(MISO), 32'd0);
    check("rdd_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tick();
    check("rdd_late_tx_valid", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    end_frame();

    // Abort a write after 5 bits
    pulses = 0;
    ss_n = 1'b0;
    tick();
    MOSI = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      tick();
      if (rx_valid) pulses++;
    end
    ss_n = 1'b1;
    tick();
    if (rx_valid) pulses++;
    tick();
    if (rx_valid) pulses++;
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'h300);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    send_frame("post_abort", 1'b0, 10'h155);
    end_frame();

    // Abort mid-transmit keeps rd_addr_done, so the next read repeats READ_DATA
    send_frame("rda2", 1'b1, 10'h2AA);
    end_frame();
    send_frame("rdd2", 1'b1, 10'h3C3);
    tx_valid = 1'b1; tx_data = 8'hF0;
    tick();
    tx_valid = 1'b0;
    tick();
    check("txabort_miso_mid", 32'(MISO), 32'd1);
    end_frame();
    check("txabort_miso", 32'(MISO), 32'd0);
    check("txabort_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd1);
    send_frame("rdd3", 1'b1, 10'h3E7);
    check("rdd3_state", 32'(dut.state_q), 32'(READ_DATA));

    // Reset during transmit
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    check("rst_mid_miso_pre", 32'(MISO), 32'd1);
    rst_n = 1'b1;
    tick();
    check("rst_mid_miso", 32'(MISO), 32'd0);
    check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_mid_rd_addr_done", 32'(dut.rd_addr_done_q), 32'd0);
    check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b0; ss_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
